// File: rtl/tap_accum.sv
// Tap accumulator: sums NUM_TAPS signed products per output sample, valid/ready on both sides.
// Build option ACCUM_SAT_EN: saturate the reduced sum and raise a sticky ovf flag.
module tap_accum #(
  parameter int DATA_WIDTH = 6,
  parameter int NUM_TAPS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] prod_in,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  output logic [((NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1)-1:0] tap_idx,
  output logic [DATA_WIDTH-1:0] sum_out,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic                  ovf
);
  localparam int IDX_W = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;
  localparam int ACC_W = DATA_WIDTH + $clog2(NUM_TAPS);
  localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(NUM_TAPS - 1);

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]        tap_idx_q, tap_idx_d;
  logic [DATA_WIDTH-1:0]   sum_out_q, sum_out_d;
  logic signed [ACC_W-1:0] prod_ext, full;
  logic [DATA_WIDTH-1:0]   reduced;
  logic                    accept, xfer, last;

  assign prod_ready = (state_q == ACCUM) | sum_ready;
  assign sum_valid  = (state_q == HOLD);
  assign tap_idx    = tap_idx_q;
  assign sum_out    = sum_out_q;

  always_comb begin
    prod_ext = {{(ACC_W-DATA_WIDTH){prod_in[DATA_WIDTH-1]}}, prod_in};
    full     = acc_q + prod_ext;
    last     = (tap_idx_q == LAST_TAP);
    accept   = prod_valid & prod_ready;
    xfer     = sum_valid & sum_ready;
  end

`ifdef ACCUM_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(2**(DATA_WIDTH-1) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
  logic clamp;
  logic ovf_q, ovf_d;

  always_comb begin
    clamp   = 1'b0;
    reduced = full[DATA_WIDTH-1:0];
    if (full > SAT_MAX) begin
      clamp   = 1'b1;
      reduced = SAT_MAX[DATA_WIDTH-1:0];
    end else if (full < SAT_MIN) begin
      clamp   = 1'b1;
      reduced = SAT_MIN[DATA_WIDTH-1:0];
    end
    ovf_d = ovf_q | (accept & last & clamp);
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  always_comb reduced = full[DATA_WIDTH-1:0];
  assign ovf = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    tap_idx_d = tap_idx_q;
    sum_out_d = sum_out_q;
    if (accept) begin
      // Tap 0 restarts the frame, so the previous frame's acc is never added in.
      acc_d = (tap_idx_q == '0) ? prod_ext : full;
      if (last) begin
        tap_idx_d = '0;
        sum_out_d = reduced;
      end else begin
        tap_idx_d = tap_idx_q + 1'b1;
      end
    end
    if (accept && last) state_d = HOLD;
    else if (xfer)      state_d = ACCUM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      tap_idx_q <= '0;
      sum_out_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      tap_idx_q <= tap_idx_d;
      sum_out_q <= sum_out_d;
    end
  end
endmodule

// File: tb/tb_tap_accum.sv
// Bench for tap_accum: constant vector table, directed corner sequences and a random run
// against a frame-level reference model (products collected per frame, summed arithmetically).
module tb_tap_accum;
  localparam int DW = 6;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] prod_in;
  logic          prod_valid;
  logic          prod_ready;
  logic [1:0]    tap_idx;
  logic [DW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready;
  logic          ovf;

  tap_accum #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
    .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .tap_idx(tap_idx), .sum_out(sum_out),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state: products of the current frame and the sum waiting downstream.
  int  frame[$];
  bit  pending;
  int  psum;
  bit  movf;
  int  sums_xfer;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endfunction

  function automatic int reduce_sum(int t, output bit clamped);
    int w;
    clamped = 1'b0;
`ifdef ACCUM_SAT_EN
    if (t > 31)       begin clamped = 1'b1; return 31;  end
    else if (t < -32) begin clamped = 1'b1; return -32; end
    return t;
`else
    w = t & 63;
    if (w >= 32) w -= 64;
    return w;
`endif
  endfunction

  function automatic int sx(logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  task automatic model_reset();
    frame.delete();
    pending = 1'b0;
    psum    = 0;
    movf    = 1'b0;
  endtask

  // One clock: drive, check outputs against the model mid-cycle, clock, update model.
  task automatic cyc(input bit v, input int d, input bit sr);
    bit acc, xf, cl;
    int tot;
    prod_valid = v;
    prod_in    = DW'(d);
    sum_ready  = sr;
    #1;
    chk("prod_ready", int'(prod_ready), pending ? int'(sr) : 1);
    chk("sum_valid", int'(sum_valid), int'(pending));
    if (pending) chk("sum_out", sx(sum_out), psum);
    chk("tap_idx", int'(tap_idx), frame.size());
    chk("ovf", int'(ovf), int'(movf));
    acc = v && (!pending || sr);
    xf  = pending && sr;
    @(posedge clk);
    if (xf) begin
      pending = 1'b0;
      sums_xfer++;
    end
    if (acc) begin
      frame.push_back(d);
      if (frame.size() == NT) begin
        tot = 0;
        foreach (frame[i]) tot += frame[i];
        psum    = reduce_sum(tot, cl);
        movf    = movf | cl;
        pending = 1'b1;
        frame.delete();
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    prod_valid = 1'b1;
    prod_in    = DW'(5);
    sum_ready  = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_tap_idx", int'(tap_idx), 0);
    chk("rst_sum_out", sx(sum_out), 0);
    chk("rst_sum_valid", int'(sum_valid), 0);
    chk("rst_ovf", int'(ovf), 0);
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    bit v; int d; bit sr;
    int tap; bit sv; int sum;
  } vec_t;
  vec_t tbl[6];

  int cycles;

  initial begin
    sums_xfer = 0;
    model_reset();
    rst = 1'b1; prod_valid = 1'b0; prod_in = '0; sum_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    do_reset();

    // 1: 3,5,-2,1 back to back; sum 7 visible for exactly one cycle.
    tbl[0] = '{1,  3, 1, 0, 0, 0};
    tbl[1] = '{1,  5, 1, 1, 0, 0};
    tbl[2] = '{1, -2, 1, 2, 0, 0};
    tbl[3] = '{1,  1, 1, 3, 0, 0};
    tbl[4] = '{0,  0, 1, 0, 1, 7};
    tbl[5] = '{0,  0, 1, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      prod_valid = tbl[i].v; prod_in = DW'(tbl[i].d); sum_ready = tbl[i].sr;
      #1;
      chk("tbl_tap_idx", int'(tap_idx), tbl[i].tap);
      chk("tbl_sum_valid", int'(sum_valid), int'(tbl[i].sv));
      if (tbl[i].sv) chk("tbl_sum_out", sx(sum_out), tbl[i].sum);
      chk("tbl_ovf", int'(ovf), 0);
      cyc(tbl[i].v, tbl[i].d, tbl[i].sr);
    end

    // 2: 31 x4
    for (int i = 0; i < 4; i++) cyc(1, 31, 1);
`ifdef ACCUM_SAT_EN
    chk("t2_sum", sx(sum_out), 31);  chk("t2_ovf", int'(ovf), 1);
`else
    chk("t2_sum", sx(sum_out), -4);  chk("t2_ovf", int'(ovf), 0);
`endif
    cyc(0, 0, 1);

    // 3: -32 x4
    for (int i = 0; i < 4; i++) cyc(1, -32, 1);
`ifdef ACCUM_SAT_EN
    chk("t3_sum", sx(sum_out), -32); chk("t3_ovf", int'(ovf), 1);
`else
    chk("t3_sum", sx(sum_out), 0);
`endif
    cyc(0, 0, 1);

    // 4: held sum with back-pressure, then transfer and tap-0 accept together.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 9, 0);
      chk("t4_hold_sum", sx(sum_out), 4);
    end
    cyc(1, 2, 1);
    chk("t4_sum_valid_after", int'(sum_valid), 0);
    chk("t4_tap_after", int'(tap_idx), 1);
    cyc(1, 3, 1); cyc(1, 4, 1); cyc(1, 5, 1);
    chk("t4_next_sum", sx(sum_out), 14);
    cyc(0, 0, 1);

    // 5: reset mid-frame discards the partial sum.
    cyc(1, 1, 1); cyc(1, 1, 1);
    do_reset();
    cyc(1, 4, 1); cyc(1, 4, 1); cyc(1, 4, 1); cyc(1, -4, 1);
    chk("t5_sum", sx(sum_out), 8);
    cyc(0, 0, 1);

    // 6: random gaps and back-pressure over 100 frames.
    do_reset();
    sums_xfer = 0;
    cycles = 0;
    while (sums_xfer < 100 && cycles < 5000) begin
      cyc(($urandom % 2) == 0, int'($urandom_range(0, 63)) - 32, ($urandom % 4) != 0);
      cycles++;
    end
    chk("t6_frames_done", sums_xfer, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
